// File: rtl/fifo_entrada_arbitro_pkg.sv
// Shared definitions for the lane input FIFO: field widths, depth,
// occupancy thresholds and the stored entry layout.
package fifo_entrada_arbitro_pkg;

    localparam int DATA_W    = 8;
    localparam int DEST_W    = 4;
    localparam int ENTRY_W   = DATA_W + DEST_W;
    localparam int DEPTH     = 8;
    localparam int ADDR_W    = 3;
    localparam int CNT_W     = ADDR_W + 1;
    localparam int AF_THRESH = 6;
    localparam int AE_THRESH = 2;

    // One stored transaction: destination tag above payload.
    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } entry_t;

    function automatic entry_t pack_entry(input logic [DEST_W-1:0] dest,
                                          input logic [DATA_W-1:0] data);
        entry_t e;
        e.dest = dest;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/fifo_entrada_arbitro_if.sv
// Producer/arbiter-facing bus of the lane FIFO.
// Handshake: push is honoured on a posedge when the FIFO is not full (or a pop
// completes in the same cycle); pop is honoured when the FIFO is not empty, and
// its entry appears on data_out/dest_out with valid_out=1 one cycle later.
interface fifo_entrada_arbitro_if;
    import fifo_entrada_arbitro_pkg::*;

    logic                push;
    logic [DATA_W-1:0]   data_in;
    logic [DEST_W-1:0]   dest_in;
    logic                pop;
    logic [DATA_W-1:0]   data_out;
    logic [DEST_W-1:0]   dest_out;
    logic                valid_out;
    logic                empty;
    logic                full;
    logic                almost_empty;
    logic                almost_full;
    logic [CNT_W-1:0]    count;
    logic                error;

    // Upstream producer plus arbiter side.
    modport master (
        output push, data_in, dest_in, pop,
        input  data_out, dest_out, valid_out, empty, full,
               almost_empty, almost_full, count, error
    );

    // FIFO side.
    modport slave (
        input  push, data_in, dest_in, pop,
        output data_out, dest_out, valid_out, empty, full,
               almost_empty, almost_full, count, error
    );
endinterface

// File: rtl/fifo_entrada_arbitro_memoria_dp.sv
// Simple dual-port storage: one write port, one synchronous read port.
// The read register doubles as the FIFO output and is cleared by reset;
// the array itself is never cleared.
module fifo_entrada_arbitro_memoria_dp
    import fifo_entrada_arbitro_pkg::*;
(
    input  logic              clk,
    input  logic              reset_L,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  entry_t            wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output entry_t            rd_data_o
);

    entry_t mem_q [DEPTH];
    entry_t rd_data_q;

    // Write port: store the entry at the write address.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port: capture on a completed pop, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_entrada_arbitro.sv
// Lane input FIFO in front of the arbiter: pointers, occupancy count,
// status flags and sticky overflow/underflow error.
module fifo_entrada_arbitro
    import fifo_entrada_arbitro_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_L,
    fifo_entrada_arbitro_if.slave bus
);

    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresholds
        $error("fifo_entrada_arbitro: thresholds must satisfy AE < AF <= DEPTH");
    end

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;
    logic              is_empty, is_full;
    logic              push_ok, pop_ok, overflow, underflow;
    entry_t            rd_entry;

    // Flags come only from the registered count.
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));

    // Accept/reject decisions and next-state values, all on pre-edge count.
    always_comb begin
        push_ok   = 1'b0;
        pop_ok    = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        valid_d   = 1'b0;
        error_d   = error_q;

        // A pop frees a slot this cycle, so a push into a full FIFO still fits.
        pop_ok    = bus.pop && !is_empty;
        push_ok   = bus.push && (!is_full || bus.pop);
        overflow  = bus.push && is_full && !bus.pop;
        underflow = bus.pop && is_empty;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
        valid_d = pop_ok;
        error_d = error_q | overflow | underflow;
    end

    // State registers; reset discards every queued entry.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    fifo_entrada_arbitro_memoria_dp u_mem (
        .clk       (clk),
        .reset_L   (reset_L),
        .wr_en_i   (push_ok && reset_L),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (pack_entry(bus.dest_in, bus.data_in)),
        .rd_en_i   (pop_ok && reset_L),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_entry)
    );

    assign bus.data_out     = rd_entry.data;
    assign bus.dest_out     = rd_entry.dest;
    assign bus.valid_out    = valid_q;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_empty = (count_q <= CNT_W'(AE_THRESH));
    assign bus.almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign bus.count        = count_q;
    assign bus.error        = error_q;

endmodule

// File: tb/tb_fifo_entrada_arbitro.sv
// Bench for the lane input FIFO: directed vectors, a reference queue of stored
// entries, and a monitor that checks every valid_out pulse against expectations.
module tb_fifo_entrada_arbitro;
    import fifo_entrada_arbitro_pkg::*;

    logic clk;
    logic reset_L;
    int   checks = 0;
    int   errors = 0;

    logic [ENTRY_W-1:0] exp_q[$];
    logic [ENTRY_W-1:0] model_q[$];

    fifo_entrada_arbitro_if bus();

    fifo_entrada_arbitro dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // One clock of stimulus; updates the reference queue with pre-edge occupancy.
    task automatic step(input logic p, input logic [DEST_W-1:0] de,
                        input logic [DATA_W-1:0] da, input logic po);
        int n;
        logic do_pop;
        logic [ENTRY_W-1:0] popped;
        n = model_q.size();
        do_pop = po && (n > 0);
        popped = '0;
        bus.push = p;
        bus.dest_in = de;
        bus.data_in = da;
        bus.pop = po;
        if (do_pop) popped = model_q.pop_front();
        if (p && (n < DEPTH || po)) model_q.push_back({de, da});
        @(posedge clk);
        if (do_pop) exp_q.push_back(popped);
        #1;
        bus.push = 1'b0;
        bus.pop = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset_L = 1'b0;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        repeat (cycles) @(posedge clk);
        model_q.delete();
        exp_q.delete();
        #1;
        reset_L = 1'b1;
    endtask

    // monitor: every output pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (reset_L) begin
            if (bus.valid_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got data=%0d dest=%0d expected no output",
                             bus.data_out, bus.dest_out);
                end else begin
                    check("pop_data", {20'd0, bus.dest_out, bus.data_out}, {20'd0, exp_q.pop_front()});
                end
            end else if (exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL missing_valid: got valid_out=0 expected 1");
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset_L = 1'b1;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.data_in = '0;
        bus.dest_in = '0;
        @(posedge clk);
        #1;

        // 1. reset
        do_reset(2);
        check("rst_count", 32'(bus.count), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_almost_empty", 32'(bus.almost_empty), 1);
        check("rst_full", 32'(bus.full), 0);
        check("rst_almost_full", 32'(bus.almost_full), 0);
        check("rst_error", 32'(bus.error), 0);
        check("rst_data_out", 32'(bus.data_out), 0);
        check("rst_valid", 32'(bus.valid_out), 0);

        // 2. fill
        for (int k = 0; k < 8; k++) begin
            step(1'b1, DEST_W'(k % 4), DATA_W'(10 * k), 1'b0);
            check("fill_count", 32'(bus.count), 32'(k + 1));
            check("fill_almost_full", 32'(bus.almost_full), (k + 1 >= 6) ? 1 : 0);
            check("fill_almost_empty", 32'(bus.almost_empty), (k + 1 <= 2) ? 1 : 0);
            check("fill_full", 32'(bus.full), (k == 7) ? 1 : 0);
        end
        check("fill_error", 32'(bus.error), 0);

        // 3. overflow
        step(1'b1, 4'd1, 8'd90, 1'b0);
        check("ovf_count", 32'(bus.count), 8);
        check("ovf_error", 32'(bus.error), 1);
        check("ovf_full", 32'(bus.full), 1);

        // 4. drain in order
        for (int k = 0; k < 8; k++) begin
            step(1'b0, '0, '0, 1'b1);
            check("drain_valid", 32'(bus.valid_out), 1);
            check("drain_value", {20'd0, bus.dest_out, bus.data_out},
                  {20'd0, 4'(k % 4), 8'(10 * k)});
        end
        check("drain_empty", 32'(bus.empty), 1);
        check("drain_error_sticky", 32'(bus.error), 1);
        step(1'b0, '0, '0, 1'b0);
        check("hold_valid", 32'(bus.valid_out), 0);
        check("hold_data", 32'(bus.data_out), 70);

        // 5a. simultaneous push/pop with count=3, wrapping the pointers
        for (int k = 0; k < 3; k++) step(1'b1, DEST_W'(k), DATA_W'(100 + k), 1'b0);
        check("pp_start_count", 32'(bus.count), 3);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, DEST_W'(k + 5), DATA_W'(200 + k), 1'b1);
            check("pp_count", 32'(bus.count), 3);
        end
        for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b1);
        check("pp_last_data", 32'(bus.data_out), 209);
        check("pp_drain_empty", 32'(bus.empty), 1);

        // 5b. push and pop on an empty FIFO
        do_reset(1);
        check("pp0_rst_error", 32'(bus.error), 0);
        step(1'b1, 4'd9, 8'd55, 1'b1);
        check("pp0_count", 32'(bus.count), 1);
        check("pp0_error", 32'(bus.error), 1);
        check("pp0_valid", 32'(bus.valid_out), 0);
        check("pp0_data_out", 32'(bus.data_out), 0);
        step(1'b0, '0, '0, 1'b1);
        check("pp0_pop_value", {20'd0, bus.dest_out, bus.data_out}, {20'd0, 4'd9, 8'd55});

        // 6. reset mid-stream
        for (int k = 0; k < 5; k++) step(1'b1, DEST_W'(k), DATA_W'(30 + k), 1'b0);
        check("mid_count", 32'(bus.count), 5);
        do_reset(1);
        check("mid_rst_empty", 32'(bus.empty), 1);
        check("mid_rst_data_out", 32'(bus.data_out), 0);
        step(1'b0, '0, '0, 1'b1);
        check("mid_underflow_valid", 32'(bus.valid_out), 0);
        check("mid_underflow_error", 32'(bus.error), 1);
        check("mid_underflow_data", 32'(bus.data_out), 0);
        check("mid_underflow_count", 32'(bus.count), 0);

        @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
